// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the round-robin FIFO write arbiter.
// Imported by the picker, the top and the bench.
package fifo_wr_arbiter_pkg;

  localparam int FIFO_WIDTH    = 16;
  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_MAX_BURST = 4;
  localparam int OWNER_W       = $clog2(ARB_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Write side of the synchronous FIFO.
// The arbiter drives it through master and the FIFO answers through slave.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH
) ();

  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_full;
  logic             fifo_almostfull;
  logic             fifo_wr_ack;
  logic             fifo_overflow;

  modport master (
    output fifo_wr_en, fifo_data_in,
    input  fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow
  );

  modport slave (
    input  fifo_wr_en, fifo_data_in,
    output fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Selects the first set request at or after rr_ptr, wrapping cyclically.
module fifo_wr_arbiter_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               winner_valid
);
  import fifo_wr_arbiter_pkg::*;

  // Scan from farthest to nearest so the candidate closest to rr_ptr wins last.
  always_comb begin : pick
    logic [IDX_W-1:0] cand;
    winner_oh    = '0;
    winner_idx   = '0;
    winner_valid = 1'b0;
    cand         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        winner_oh       = '0;
        winner_oh[cand] = 1'b1;
        winner_idx      = cand;
        winner_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of the FIFO write port.
// Grants bounded bursts, never writes into a full FIFO, and flags lost writes.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = fifo_wr_arbiter_pkg::ARB_NUM_REQ,
  parameter  int FIFO_WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH,
  parameter  int MAX_BURST  = fifo_wr_arbiter_pkg::ARB_MAX_BURST,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  fifo_wr_arbiter_if.master             fifo,
  output logic [IDX_W-1:0]              owner,
  output logic                          busy,
  output logic                          drop_err,
  output logic [15:0]                   wr_count
);
  import fifo_wr_arbiter_pkg::*;

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       owner_q;
  logic [CNT_W-1:0]       burst_cnt_q;
  logic                   wr_pend_q;
  logic                   space;
  logic                   grant_any;
  logic [IDX_W-1:0]       grant_idx;
  logic [FIFO_WIDTH-1:0]  grant_data;
  logic [NUM_REQ-1:0]     win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_valid;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  fifo_wr_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req          (req),
    .rr_ptr       (rr_ptr_q),
    .winner_oh    (win_oh),
    .winner_idx   (win_idx),
    .winner_valid (win_valid)
  );

  // A write already registered but not yet stored may be the one that fills the FIFO.
  always_comb begin
    space      = !fifo.fifo_full && !(fifo.fifo_almostfull && fifo.fifo_wr_en);
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt        = '0;
    grant_any  = 1'b0;
    grant_idx  = owner_q;
    case (state_q)
      IDLE: begin
        if (win_valid && space) begin
          gnt       = win_oh;
          grant_any = 1'b1;
          grant_idx = win_idx;
          state_d   = BURST;
        end
      end
      BURST: begin
        if (req[owner_q] && space && (burst_cnt_q < CNT_MAX)) begin
          gnt[owner_q] = 1'b1;
          grant_any    = 1'b1;
        end
        if (req[owner_q] && !space) begin
          state_d = HOLD;
        end else if (!req[owner_q] || (burst_cnt_q == CNT_MAX)) begin
          rr_ptr_d = next_idx(owner_q);
          state_d  = IDLE;
        end
      end
      HOLD: begin
        if (!req[owner_q]) begin
          rr_ptr_d = next_idx(owner_q);
          state_d  = IDLE;
        end else if (space) begin
          state_d = BURST;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      gnt       = '0;
      grant_any = 1'b0;
    end
    grant_data = req_data[int'(grant_idx)*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Reset drops any in-flight write and the pending acknowledge check with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      rr_ptr_q          <= '0;
      owner_q           <= '0;
      burst_cnt_q       <= '0;
      wr_pend_q         <= 1'b0;
      drop_err          <= 1'b0;
      wr_count          <= '0;
      fifo.fifo_wr_en   <= 1'b0;
      fifo.fifo_data_in <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_pend_q <= fifo.fifo_wr_en;
      if (grant_any) begin
        fifo.fifo_wr_en   <= 1'b1;
        fifo.fifo_data_in <= grant_data;
        owner_q           <= grant_idx;
        burst_cnt_q       <= (state_q == IDLE) ? CNT_W'(1) : burst_cnt_q + 1'b1;
      end else begin
        fifo.fifo_wr_en <= 1'b0;
      end
      if ((wr_pend_q && !fifo.fifo_wr_ack) || fifo.fifo_overflow) begin
        drop_err <= 1'b1;
      end
      if (wr_pend_q && fifo.fifo_wr_ack) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a depth-8 FIFO model and producer models.
// A second instance with MAX_BURST=1 runs against an always-draining FIFO.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NR    = 4;
  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]      req = '0;
  logic [NR-1:0]      gnt;
  logic [NR*W-1:0]    req_data;
  logic [OWNER_W-1:0] owner;
  logic               busy, drop_err;
  logic [15:0]        wr_count;

  logic [NR-1:0]      req1 = '0;
  logic [NR-1:0]      gnt1;
  logic [NR*W-1:0]    req_data1;
  logic [OWNER_W-1:0] owner1;
  logic               busy1, drop_err1;
  logic [15:0]        wr_count1;

  fifo_wr_arbiter_if #(.WIDTH(W)) fif ();
  fifo_wr_arbiter_if #(.WIDTH(W)) fif1 ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo(fif), .owner(owner), .busy(busy), .drop_err(drop_err), .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_data(req_data1), .gnt(gnt1),
    .fifo(fif1), .owner(owner1), .busy(busy1), .drop_err(drop_err1), .wr_count(wr_count1)
  );

  // Producers: word k of producer i is (i+1)*0x1000 + k; advances on req&&gnt.
  logic        prod_clr = 1'b0;
  logic [15:0] seq [NR];
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (prod_clr) seq[i] <= '0;
      else if (req[i] && gnt[i]) seq[i] <= seq[i] + 16'd1;
    end
  end
  always_comb begin
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 16'((i + 1) * 'h1000) + seq[i];
  end
  always_comb begin
    for (int i = 0; i < NR; i++) req_data1[i*W +: W] = 16'hA0A0 + 16'(i);
  end

  // Depth-8 FIFO model: counts occupancy, registered ack/overflow.
  int   fill      = 0;
  logic fifo_clr  = 1'b0;
  logic pop       = 1'b0;
  logic push_tb   = 1'b0;
  logic nack_kill = 1'b0;
  logic ack_m     = 1'b0;
  logic ovf_m     = 1'b0;
  logic wr_req;
  assign wr_req = fif.fifo_wr_en || push_tb;
  always @(posedge clk) begin
    if (fifo_clr) begin
      fill  <= 0;
      ack_m <= 1'b0;
      ovf_m <= 1'b0;
    end else begin
      fill  <= fill + ((wr_req && fill < DEPTH) ? 1 : 0) - ((pop && fill > 0) ? 1 : 0);
      ack_m <= fif.fifo_wr_en && (fill < DEPTH);
      ovf_m <= wr_req && (fill >= DEPTH);
    end
  end
  assign fif.fifo_full       = (fill == DEPTH);
  assign fif.fifo_almostfull = (fill == DEPTH - 1);
  assign fif.fifo_wr_ack     = ack_m && !nack_kill;
  assign fif.fifo_overflow   = ovf_m;

  logic ack1 = 1'b0;
  always @(posedge clk) ack1 <= fif1.fifo_wr_en;
  assign fif1.fifo_full       = 1'b0;
  assign fif1.fifo_almostfull = 1'b0;
  assign fif1.fifo_wr_ack     = ack1;
  assign fif1.fifo_overflow   = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;

  // Monitor: every cycle the main DUT presents a write, it must match the next expected word.
  always @(negedge clk) begin
    if (fif.fifo_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_write unexpected write actual=%h required=none", fif.fifo_data_in);
      end else begin
        exp_word = exp_q.pop_front();
        if (fif.fifo_data_in !== exp_word) begin
          errors++;
          $display("[TB] FAIL sb_write actual=%h required=%h", fif.fifo_data_in, exp_word);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic p, input logic rst, input logic kill);
    @(negedge clk);
    req       = r;
    pop       = p;
    rst_n     = rst;
    nack_kill = kill;
    #1;
  endtask

  task automatic resetAll();
    @(negedge clk);
    rst_n = 1'b0; req = '0; req1 = '0; pop = 1'b0; push_tb = 1'b0; nack_kill = 1'b0;
    fifo_clr = 1'b1; prod_clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    fifo_clr = 1'b0; prod_clr = 1'b0;
  endtask

  task automatic pushExp(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 16'(k));
  endtask

  logic [3:0] t1_gnt [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
  logic [3:0] t2_gnt [12] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h2, 4'h0};
  logic [3:0] t3_gnt [12] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
  logic [3:0] t6_gnt [10] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};

  initial begin
    // Reset values, with requests pending to show gnt is gated.
    resetAll();
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_wr_en", 32'(fif.fifo_wr_en), 32'h0);
    checkOutput("rst_data", 32'(fif.fifo_data_in), 32'h0);
    checkOutput("rst_drop_err", 32'(drop_err), 32'h0);
    checkOutput("rst_wr_count", 32'(wr_count), 32'h0);

    // All requesting into an empty depth-8 FIFO: two bursts then full.
    pushExp(16'h1000, 4);
    pushExp(16'h2000, 4);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'hF, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("t1_gnt_c%0d", c), 32'(gnt), 32'(t1_gnt[c]));
    end
    for (int c = 10; c < 16; c++) begin
      applyStimulus(4'hF, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("t1_gnt_c%0d", c), 32'(gnt), 32'h0);
    end
    checkOutput("t1_wr_count", 32'(wr_count), 32'd8);
    checkOutput("t1_fifo_fill", 32'(fill), 32'd8);
    checkOutput("t1_busy_hold", 32'(busy), 32'h1);
    checkOutput("t1_drop_err", 32'(drop_err), 32'h0);
    checkOutput("t1_sb_drain", 32'(exp_q.size()), 32'h0);

    // Sparse requests with a draining FIFO: 1, 3, then back to 1.
    resetAll();
    pushExp(16'h2000, 4);
    pushExp(16'h4000, 4);
    pushExp(16'h2004, 1);
    for (int c = 0; c < 12; c++) begin
      applyStimulus((c < 11) ? 4'hA : 4'h0, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("t2_gnt_c%0d", c), 32'(gnt), 32'(t2_gnt[c]));
      if (c == 1)  checkOutput("t2_owner_c1", 32'(owner), 32'd1);
      if (c == 6)  checkOutput("t2_owner_c6", 32'(owner), 32'd3);
      if (c == 11) checkOutput("t2_owner_c11", 32'(owner), 32'd1);
    end
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_busy_end", 32'(busy), 32'h0);
    checkOutput("t2_sb_drain", 32'(exp_q.size()), 32'h0);

    // FIFO prefilled to 6: two writes, HOLD, one read releases one more write.
    resetAll();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      push_tb = 1'b1;
    end
    @(negedge clk);
    push_tb = 1'b0;
    pushExp(16'h1000, 3);
    for (int c = 0; c < 12; c++) begin
      applyStimulus(4'h1, (c == 6), 1'b1, 1'b0);
      checkOutput($sformatf("t3_gnt_c%0d", c), 32'(gnt), 32'(t3_gnt[c]));
      if (c == 5) checkOutput("t3_busy_hold", 32'(busy), 32'h1);
    end
    checkOutput("t3_wr_count", 32'(wr_count), 32'd3);
    checkOutput("t3_fifo_fill", 32'(fill), 32'd8);
    checkOutput("t3_drop_err", 32'(drop_err), 32'h0);
    checkOutput("t3_sb_drain", 32'(exp_q.size()), 32'h0);

    // Reset on the second cycle of requester 2's burst; rr pointer must restart at 0.
    resetAll();
    pushExp(16'h1000, 4);
    pushExp(16'h3000, 1);
    pushExp(16'h1004, 1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'h1, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("t4_gnt_c%0d", c), 32'(gnt), (c < 4) ? 32'h1 : 32'h0);
    end
    applyStimulus(4'h4, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_gnt_c5", 32'(gnt), 32'h4);
    applyStimulus(4'h4, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_gnt_in_rst", 32'(gnt), 32'h0);
    applyStimulus(4'h4, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_wr_en", 32'(fif.fifo_wr_en), 32'h0);
    checkOutput("t4_busy", 32'(busy), 32'h0);
    checkOutput("t4_owner", 32'(owner), 32'h0);
    checkOutput("t4_wr_count", 32'(wr_count), 32'h0);
    checkOutput("t4_gnt_c7", 32'(gnt), 32'h0);
    applyStimulus(4'h5, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_gnt_restart", 32'(gnt), 32'h1);
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_sb_drain", 32'(exp_q.size()), 32'h0);

    // Missing acknowledge sets a sticky drop_err.
    resetAll();
    pushExp(16'h1000, 8);
    for (int c = 0; c < 13; c++) begin
      applyStimulus((c < 10) ? 4'h1 : 4'h0, 1'b0, 1'b1, (c == 2));
      if (c == 2) checkOutput("t5_drop_err_before", 32'(drop_err), 32'h0);
      if (c == 3) checkOutput("t5_drop_err_set", 32'(drop_err), 32'h1);
      if (c == 5) checkOutput("t5_gnt_c5", 32'(gnt), 32'h1);
    end
    checkOutput("t5_drop_err_sticky", 32'(drop_err), 32'h1);
    checkOutput("t5_wr_count", 32'(wr_count), 32'd7);
    checkOutput("t5_sb_drain", 32'(exp_q.size()), 32'h0);
    resetAll();
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_drop_err_cleared", 32'(drop_err), 32'h0);

    // MAX_BURST=1 instance: strict rotation, one write every two cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req1  = 4'hF;
      rst_n = 1'b1;
      #1;
      checkOutput($sformatf("t6_gnt_c%0d", c), 32'(gnt1), 32'(t6_gnt[c]));
      if (c == 2) checkOutput("t6_wr_en_gap", 32'(fif1.fifo_wr_en), 32'h0);
      if (c == 1 || c == 3 || c == 5 || c == 7) begin
        checkOutput($sformatf("t6_wr_en_c%0d", c), 32'(fif1.fifo_wr_en), 32'h1);
        checkOutput($sformatf("t6_data_c%0d", c), 32'(fif1.fifo_data_in), 32'(16'hA0A0 + 16'((c - 1) / 2)));
      end
    end
    checkOutput("t6_wr_count", 32'(wr_count1), 32'd4);
    checkOutput("t6_drop_err", 32'(drop_err1), 32'h0);
    req1 = 4'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
